// File: rtl/spi_master_multi.sv
// Full-duplex SPI master with a valid/ready word interface, per-transfer CPOL/CPHA,
// multiple chip selects and chained transfers that keep cs_n asserted between words.
module spi_master_multi #(
    parameter int DATA_W    = 8,
    parameter int CLK_DIV   = 8,
    parameter int NUM_CS    = 1,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int MSB_FIRST = 1
) (
    input  logic                                         clk_mmcm,
    input  logic                                         rst_n,
    input  logic [DATA_W-1:0]                            tx_data,
    input  logic                                         tx_valid,
    output logic                                         tx_ready,
    input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
    input  logic                                         cpol,
    input  logic                                         cpha,
    input  logic                                         cont,
    output logic [DATA_W-1:0]                            rx_data,
    output logic                                         rx_valid,
    output logic                                         busy,
    output logic                                         sclk,
    output logic                                         mosi,
    input  logic                                         miso,
    output logic [NUM_CS-1:0]                            cs_n
);

    localparam int CS_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
    localparam int BIT_W   = $clog2(DATA_W) + 1;
    localparam int MAX_A   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
    localparam int CNT_MAX = (MAX_A > CS_HOLD) ? MAX_A : CS_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_CHAIN
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [BIT_W-1:0]   bit_cnt_reg;
    logic [DATA_W-1:0]  tx_shift_reg;
    logic [DATA_W-1:0]  rx_shift_reg;
    logic               cpol_reg;
    logic               cpha_reg;
    logic               cont_reg;

    logic [NUM_CS-1:0]  cs_dec;
    logic               accept;
    logic               leading;
    logic               sample_edge;
    logic               xfer_done;
    logic               edge_now;
    logic               load_cpha;

    // Out-of-range selects match no bit, so the word still runs with every cs_n high.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_CS; gi++) begin : g_cs
            assign cs_dec[gi] = (cs_sel != CS_W'(gi));
        end
    endgenerate

    function automatic logic first_bit(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    assign accept      = tx_valid & tx_ready;
    assign leading     = (sclk == cpol_reg);
    assign sample_edge = leading ^ cpha_reg;
    // All samples taken and sclk back at its idle level: the final trailing edge has passed.
    assign xfer_done   = (bit_cnt_reg == BIT_W'(DATA_W)) && leading;
    assign edge_now    = (cnt_reg == '0) &&
                         ((state_reg == S_SETUP) || ((state_reg == S_XFER) && !xfer_done));
    assign load_cpha   = (state_reg == S_IDLE) ? cpha : cpha_reg;

    always_ff @(posedge clk_mmcm or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            bit_cnt_reg  <= '0;
            tx_shift_reg <= '0;
            rx_shift_reg <= '0;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            cont_reg     <= 1'b0;
            tx_ready     <= 1'b1;
            busy         <= 1'b0;
            rx_valid     <= 1'b0;
            rx_data      <= '0;
            sclk         <= 1'b0;
            mosi         <= 1'b0;
            cs_n         <= '1;
        end else begin
            rx_valid <= 1'b0;

            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        state_reg <= S_SETUP;
                        busy      <= 1'b1;
                        cs_n      <= cs_dec;
                        sclk      <= cpol;
                        cpol_reg  <= cpol;
                        cpha_reg  <= cpha;
                        cnt_reg   <= CNT_W'(CS_SETUP - 1);
                    end
                end
                S_SETUP: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_XFER;
                        cnt_reg   <= CNT_W'(CLK_DIV - 1);
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                S_XFER: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else if (xfer_done) begin
                        state_reg <= S_HOLD;
                        rx_data   <= rx_shift_reg;
                        rx_valid  <= 1'b1;
                        cnt_reg   <= CNT_W'(CS_HOLD - 1);
                    end else begin
                        cnt_reg <= CNT_W'(CLK_DIV - 1);
                    end
                end
                S_HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end else begin
                        tx_ready <= 1'b1;
                        if (cont_reg) begin
                            state_reg <= S_CHAIN;
                        end else begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                            cs_n      <= '1;
                        end
                    end
                end
                S_CHAIN: begin
                    // Chained words keep the first word's chip select and mode.
                    if (accept) begin
                        state_reg <= S_XFER;
                        cnt_reg   <= CNT_W'(CLK_DIV - 1);
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                    busy      <= 1'b0;
                    tx_ready  <= 1'b1;
                    cs_n      <= '1;
                end
            endcase

            if (accept) begin
                tx_ready    <= 1'b0;
                cont_reg    <= cont;
                bit_cnt_reg <= '0;
                if (!load_cpha) begin
                    mosi         <= first_bit(tx_data);
                    tx_shift_reg <= shift_out(tx_data);
                end else begin
                    tx_shift_reg <= tx_data;
                end
            end

            if (edge_now) begin
                sclk <= ~sclk;
                if (sample_edge) begin
                    rx_shift_reg <= shift_in(rx_shift_reg, miso);
                    bit_cnt_reg  <= bit_cnt_reg + 1'b1;
                end else begin
                    mosi         <= first_bit(tx_shift_reg);
                    tx_shift_reg <= shift_out(tx_shift_reg);
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: an 8-bit MSB-first instance with five chip
// selects and a 16-bit LSB-first instance, both checked through rx scoreboards.
module tb_spi_master_multi;

    localparam int CD = 4;
    localparam int SETUP_C = 2;
    localparam int HOLD_C = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;

    // Instance A: five selects so that select 5 is representable and out of range.
    logic [7:0]  tx_data_a = '0;
    logic        tx_valid_a = 1'b0;
    logic        tx_ready_a;
    logic [2:0]  cs_sel_a = '0;
    logic        cpol_a = 1'b0, cpha_a = 1'b0, cont_a = 1'b0;
    logic [7:0]  rx_data_a;
    logic        rx_valid_a, busy_a, sclk_a, mosi_a, miso_a;
    logic [4:0]  cs_n_a;

    logic [15:0] tx_data_b = '0;
    logic        tx_valid_b = 1'b0;
    logic        tx_ready_b;
    logic [0:0]  cs_sel_b = '0;
    logic [15:0] rx_data_b;
    logic        rx_valid_b, busy_b, sclk_b, mosi_b;
    logic [0:0]  cs_n_b;

    logic        slave_en = 1'b0;
    logic        miso_slave = 1'b0;
    logic [7:0]  slave_word = '0;
    int          slave_idx = 0;

    assign miso_a = slave_en ? miso_slave : mosi_a;

    spi_master_multi #(
        .DATA_W(8), .CLK_DIV(CD), .NUM_CS(5), .CS_SETUP(SETUP_C), .CS_HOLD(HOLD_C), .MSB_FIRST(1)
    ) dut_a (
        .clk_mmcm(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .cs_sel(cs_sel_a), .cpol(cpol_a), .cpha(cpha_a), .cont(cont_a),
        .rx_data(rx_data_a), .rx_valid(rx_valid_a), .busy(busy_a), .sclk(sclk_a),
        .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
    );

    spi_master_multi #(
        .DATA_W(16), .CLK_DIV(CD), .NUM_CS(1), .CS_SETUP(SETUP_C), .CS_HOLD(HOLD_C), .MSB_FIRST(0)
    ) dut_b (
        .clk_mmcm(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .cs_sel(cs_sel_b), .cpol(1'b0), .cpha(1'b0), .cont(1'b0),
        .rx_data(rx_data_b), .rx_valid(rx_valid_b), .busy(busy_b), .sclk(sclk_b),
        .mosi(mosi_b), .miso(mosi_b), .cs_n(cs_n_b)
    );

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15 - i];
        return r;
    endfunction

    // Mode-3 slave: presents its next bit on each falling (leading) sclk edge.
    always @(negedge sclk_a) begin
        if (slave_en && slave_idx < 8) begin
            miso_slave = slave_word[3'(7 - slave_idx)];
            slave_idx++;
        end
    end

    logic [7:0]  q_a[$];
    logic [15:0] q_b[$];
    logic [7:0]  exp_a;
    logic [15:0] exp_b;

    int cyc_a = 0, edge_cnt_a = 0, rise_cnt_a = 0, rxv_cnt_a = 0;
    int cs0_low_a = 0, cs0_pulses_a = 0, acc_cyc_a = 0;
    logic gap_pending = 1'b0;
    logic [31:0] mosi_cap_a = '0;
    logic [4:0] ever_low_a = '0;
    logic sclk_prev_a = 1'b0, busy_prev_a = 1'b0, cs0_prev_a = 1'b1;

    always @(negedge clk) begin
        cyc_a++;
        // The idle-level change at accept is not an sclk edge; count only while already busy.
        if (busy_prev_a && sclk_a != sclk_prev_a) begin
            edge_cnt_a++;
            if (sclk_a) begin
                rise_cnt_a++;
                mosi_cap_a = {mosi_cap_a[30:0], mosi_a};
            end
            if (gap_pending) begin
                check("chain_gap", 32'(cyc_a - acc_cyc_a), 32'(1 + CD));
                gap_pending = 1'b0;
            end
        end
        if (tx_valid_a && tx_ready_a && busy_a) begin
            acc_cyc_a = cyc_a;
            gap_pending = 1'b1;
        end
        if (!cs_n_a[0]) cs0_low_a++;
        if (cs0_prev_a && !cs_n_a[0]) cs0_pulses_a++;
        ever_low_a |= ~cs_n_a;
        if (rx_valid_a) begin
            rxv_cnt_a++;
            if (q_a.size() == 0) check("rx_a_unexpected", 32'(q_a.size()), 32'd1);
            else begin
                exp_a = q_a.pop_front();
                check("rx_data_a", 32'(rx_data_a), 32'(exp_a));
            end
        end
        sclk_prev_a = sclk_a;
        busy_prev_a = busy_a;
        cs0_prev_a = cs_n_a[0];
    end

    int rise_cnt_b = 0;
    logic [15:0] cap_b = '0;
    logic sclk_prev_b = 1'b0, busy_prev_b = 1'b0;

    always @(negedge clk) begin
        if (busy_prev_b && sclk_b != sclk_prev_b && sclk_b) begin
            rise_cnt_b++;
            cap_b = {cap_b[14:0], mosi_b};
        end
        if (rx_valid_b) begin
            if (q_b.size() == 0) check("rx_b_unexpected", 32'(q_b.size()), 32'd1);
            else begin
                exp_b = q_b.pop_front();
                check("rx_data_b", 32'(rx_data_b), 32'(exp_b));
            end
        end
        sclk_prev_b = sclk_b;
        busy_prev_b = busy_b;
    end

    task automatic send_a(input logic [7:0] d, input logic [2:0] sel, input logic pol,
                          input logic pha, input logic cn, input logic [7:0] exp_rx);
        int k = 0;
        tx_data_a = d; cs_sel_a = sel; cpol_a = pol; cpha_a = pha; cont_a = cn;
        tx_valid_a = 1'b1;
        while (!tx_ready_a && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("accept_a", 32'(tx_ready_a), 32'd1);
        if (tx_ready_a) q_a.push_back(exp_rx);
        @(negedge clk);
        tx_valid_a = 1'b0;
    endtask

    task automatic wait_idle_a();
        int k = 0;
        while ((busy_a || !tx_ready_a) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("idle_a", 32'(busy_a), 32'd0);
    endtask

    task automatic send_b(input logic [15:0] d);
        int k = 0;
        tx_data_b = d;
        tx_valid_b = 1'b1;
        while (!tx_ready_b && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("accept_b", 32'(tx_ready_b), 32'd1);
        if (tx_ready_b) q_b.push_back(d);
        @(negedge clk);
        tx_valid_b = 1'b0;
        k = 0;
        while ((busy_b || !tx_ready_b) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("idle_b", 32'(busy_b), 32'd0);
    endtask

    logic [7:0] msg [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h57,
                             8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h0D, 8'h0A};

    initial begin
        int n;
        int k;
        int rxv_before;
        logic prev;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_sclk", 32'(sclk_a), 32'd0);
        check("rst_mosi", 32'(mosi_a), 32'd0);
        check("rst_cs_n", 32'(cs_n_a), 32'h1F);
        check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
        check("rst_rx_data", 32'(rx_data_a), 32'd0);
        check("rst_rx_data_b", 32'(rx_data_b), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0 loopback
        rise_cnt_a = 0; edge_cnt_a = 0; mosi_cap_a = '0; rxv_cnt_a = 0;
        cs0_low_a = 0; cs0_pulses_a = 0;
        send_a(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'hA5);
        wait_idle_a();
        check("m0_rises", 32'(rise_cnt_a), 32'd8);
        check("m0_mosi_bits", mosi_cap_a, 32'hA5);
        check("m0_rx_pulses", 32'(rxv_cnt_a), 32'd1);
        check("m0_cs_low_cycles", 32'(cs0_low_a), 32'(SETUP_C + 2 * 8 * CD + HOLD_C));
        check("m0_cs_pulses", 32'(cs0_pulses_a), 32'd1);
        check("m0_rx_data", 32'(rx_data_a), 32'hA5);

        // Mode 3 against the slave model
        slave_word = 8'hC3; slave_idx = 0; slave_en = 1'b1;
        rise_cnt_a = 0; edge_cnt_a = 0; mosi_cap_a = '0;
        send_a(8'h3C, 3'd0, 1'b1, 1'b1, 1'b0, 8'hC3);
        check("m3_sclk_idle_before", 32'(sclk_a), 32'd1);
        wait_idle_a();
        check("m3_sclk_idle_after", 32'(sclk_a), 32'd1);
        check("m3_edges", 32'(edge_cnt_a), 32'd16);
        check("m3_mosi_bits", mosi_cap_a, 32'h3C);
        slave_en = 1'b0;

        // Chained message on cs 0
        rxv_cnt_a = 0; cs0_pulses_a = 0;
        for (int i = 0; i < 14; i++)
            send_a(msg[i], 3'd0, 1'b0, 1'b0, (msg[i] != 8'h0A), msg[i]);
        wait_idle_a();
        check("chain_cs_pulses", 32'(cs0_pulses_a), 32'd1);
        check("chain_rx_pulses", 32'(rxv_cnt_a), 32'd14);
        check("chain_queue_empty", 32'(q_a.size()), 32'd0);

        // Multi-CS: valid select 2, then out-of-range select 5
        ever_low_a = '0;
        send_a(8'h96, 3'd2, 1'b0, 1'b0, 1'b0, 8'h96);
        wait_idle_a();
        check("cs2_only", 32'(ever_low_a), 32'h04);
        ever_low_a = '0; edge_cnt_a = 0;
        send_a(8'h69, 3'd5, 1'b0, 1'b0, 1'b0, 8'h69);
        wait_idle_a();
        check("cs5_none", 32'(ever_low_a), 32'h00);
        check("cs5_edges", 32'(edge_cnt_a), 32'd16);

        // Reset after the 5th sclk edge
        send_a(8'hC7, 3'd0, 1'b0, 1'b0, 1'b0, 8'hC7);
        rxv_before = rxv_cnt_a;
        prev = sclk_a; n = 0; k = 0;
        while (n < 5 && k < 3000) begin
            @(negedge clk);
            k++;
            if (sclk_a != prev) n++;
            prev = sclk_a;
        end
        check("rst_mid_edges", 32'(n), 32'd5);
        rst_n = 1'b0;
        #1;
        check("rst_mid_cs_n", 32'(cs_n_a), 32'h1F);
        check("rst_mid_sclk", 32'(sclk_a), 32'd0);
        check("rst_mid_rx_valid", 32'(rx_valid_a), 32'd0);
        check("rst_mid_tx_ready", 32'(tx_ready_a), 32'd1);
        repeat (3) @(negedge clk);
        check("rst_mid_no_pulse", 32'(rxv_cnt_a - rxv_before), 32'd0);
        check("rst_mid_pending", 32'(q_a.size()), 32'd1);
        q_a.delete();
        rst_n = 1'b1;
        @(negedge clk);
        send_a(8'h5A, 3'd0, 1'b0, 1'b0, 1'b0, 8'h5A);
        wait_idle_a();
        check("post_rst_rx_data", 32'(rx_data_a), 32'h5A);
        check("post_rst_queue_empty", 32'(q_a.size()), 32'd0);

        // Wide LSB-first instance
        rise_cnt_b = 0; cap_b = '0;
        send_b(16'h8001);
        check("wide_rises", 32'(rise_cnt_b), 32'd16);
        check("wide_first_bit", 32'(cap_b[15]), 32'd1);
        check("wide_last_bit", 32'(cap_b[0]), 32'd1);
        check("wide_rx_data", 32'(rx_data_b), 32'h8001);
        cap_b = '0;
        send_b(16'h1234);
        check("wide_order", 32'(cap_b), 32'(rev16(16'h1234)));
        check("wide_queue_empty", 32'(q_b.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
